phase_timer: RTL and testbench

Tick-driven countdown timer. It consumes the 1-cycle `tick` pulses produced by the divider and times each traffic-light phase (red/amber/green durations) for the controller FSM. The FSM loads a duration in ticks and receives a 1-cycle `expired` pulse when that duration has elapsed. The block also watches the tick stream and flags a fault if the tick source stalls during a phase.

---
 rtl/phase_timer.sv | 141 ++++++++++++++
 tb/tb_phase_timer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//
// Tick-driven countdown timer for one traffic-light phase. The controller
// loads a duration (in ticks) and receives a single-cycle `expired` pulse
// when the last tick of that duration has been counted. A watchdog counts
// clk cycles between ticks while the timer is counting. If the tick source
// stalls for GAP_MAX cycles, the watchdog raises a sticky `tick_fault`.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   tick       in   1      1-cycle timebase pulse from the divider
//   load       in   1      start (or restart) a phase with load_val
//   load_val   in   CNT_W  phase duration in ticks (0 = expire at once)
//   pause      in   1      level; freeze the countdown while high
//   abort      in   1      cancel the current phase, no expiry pulse
//   remaining  out  CNT_W  ticks left in the current phase (registered)
//   busy       out  1      high while a phase is running or held
//   expired    out  1      1-cycle pulse at phase end
//   tick_fault out  1      sticky; tick stream stalled during a phase
// ---------------------------------------------------------------------------
module phase_timer #(
   parameter int CNT_W   = 8,
   parameter int GAP_MAX = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             pause,
   input  logic             abort,
   output logic [CNT_W-1:0] remaining,
   output logic             busy,
   output logic             expired,
   output logic             tick_fault
);

   localparam int GAP_W = $clog2(GAP_MAX + 1);
   localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_MAX);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic [GAP_W-1:0] gap;

   // Every output is a flop, so no input reaches an output combinationally.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout; the default below is
      // overridden by any later assignment in the same edge, which makes
      // expired a one-cycle pulse unless a branch explicitly raises it.
      expired <= 1'b0;

      if (rst) begin
         state      <= IDLE;
         remaining  <= '0;
         busy       <= 1'b0;
         expired    <= 1'b0;
         tick_fault <= 1'b0;
         gap        <= '0;
      end else if (abort) begin
         // Cancel without an expiry pulse; a recorded fault survives abort.
         state     <= IDLE;
         remaining <= '0;
         busy      <= 1'b0;
         gap       <= '0;
      end else if (load) begin
         // Any load (including a mid-phase reload) starts a clean phase.
         // A tick in this same cycle is deliberately not counted.
         tick_fault <= 1'b0;
         gap        <= '0;
         if (load_val != '0) begin
            remaining <= load_val;
            state     <= RUN;
            busy      <= 1'b1;
         end else begin
            remaining <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            expired   <= 1'b1;
         end
      end else begin
         unique case (state)
            IDLE: begin
               gap <= '0;
            end

            RUN: begin
               if (pause) begin
                  // Entering HOLD swallows a coincident tick; the gap
                  // count is frozen until the phase resumes.
                  state <= HOLD;
               end else if (tick) begin
                  gap <= '0;
                  if (remaining > CNT_W'(1)) begin
                     remaining <= remaining - CNT_W'(1);
                  end else begin
                     // Final tick: end the phase. remaining is never 0 in
                     // RUN, so this cannot wrap.
                     remaining <= '0;
                     state     <= IDLE;
                     busy      <= 1'b0;
                     expired   <= 1'b1;
                     gap       <= '0;
                  end
               end else begin
                  // Saturate so a long stall cannot wrap the counter back
                  // below the limit; the fault is sticky regardless.
                  if (gap != GAP_LIM) begin
                     gap <= gap + GAP_W'(1);
                  end
                  if (gap == GAP_LAST) begin
                     tick_fault <= 1'b1;
                  end
               end
            end

            HOLD: begin
               // Missed ticks are not caught up on resume.
               if (!pause) begin
                  state <= RUN;
               end
            end

            default: begin
               state     <= IDLE;
               remaining <= '0;
               busy      <= 1'b0;
               gap       <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_timer.sv
// ---------------------------------------------------------------------------
// tb_phase_timer
//
// Directed self-checking bench for phase_timer with GAP_MAX = 8. Inputs are
// driven 1 ns after each rising edge and outputs are sampled at the same
// point, so every observation reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_phase_timer;

   localparam int CNT_W   = 8;
   localparam int GAP_MAX = 8;

   logic             clk;
   logic             rst;
   logic             tick;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             pause;
   logic             abort;
   logic [CNT_W-1:0] remaining;
   logic             busy;
   logic             expired;
   logic             tick_fault;

   int tests_run;
   int tests_failed;

   phase_timer #(
      .CNT_W   (CNT_W),
      .GAP_MAX (GAP_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .load       (load),
      .load_val   (load_val),
      .pause      (pause),
      .abort      (abort),
      .remaining  (remaining),
      .busy       (busy),
      .expired    (expired),
      .tick_fault (tick_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs set before the call are sampled at that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic do_load(input logic [CNT_W-1:0] v);
      load     = 1'b1;
      load_val = v;
      step();
      load     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++; if (remaining !== 8'd0) begin tests_failed++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL reset_expired got=%b exp=0", expired); end
      tests_run++; if (tick_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault got=%b exp=0", tick_fault); end
   endtask

   // Load 3, one tick every 5 clocks: 3 -> 2 -> 1 -> 0 with a single pulse.
   task automatic test_basic();
      do_load(8'd3);
      tests_run++; if (remaining !== 8'd3) begin tests_failed++; $display("FAIL basic_load got=%0d exp=3", remaining); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got=%b exp=1", busy); end
      for (int k = 1; k <= 3; k++) begin
         idle(4);
         tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL basic_early_exp k=%0d got=%b exp=0", k, expired); end
         do_tick();
         tests_run++; if (remaining !== 8'(3 - k)) begin tests_failed++; $display("FAIL basic_rem k=%0d got=%0d exp=%0d", k, remaining, 3 - k); end
         tests_run++; if (expired !== (k == 3)) begin tests_failed++; $display("FAIL basic_exp k=%0d got=%b exp=%b", k, expired, k == 3); end
         tests_run++; if (busy !== (k != 3)) begin tests_failed++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, busy, k != 3); end
      end
      step();
      tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL basic_pulse_width got=%b exp=0", expired); end
      tests_run++; if (tick_fault !== 1'b0) begin tests_failed++; $display("FAIL basic_fault got=%b exp=0", tick_fault); end
   endtask

   task automatic test_zero_and_precedence();
      do_load(8'd0);
      tests_run++; if (expired !== 1'b1) begin tests_failed++; $display("FAIL zero_exp got=%b exp=1", expired); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy got=%b exp=0", busy); end
      step();
      tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL zero_pulse_width got=%b exp=0", expired); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_after got=%b exp=0", busy); end
      // Load coincident with a tick: the tick must not be counted.
      tick = 1'b1;
      do_load(8'd4);
      tick = 1'b0;
      tests_run++; if (remaining !== 8'd4) begin tests_failed++; $display("FAIL load_tick_rem got=%0d exp=4", remaining); end
      abort = 1'b1; step(); abort = 1'b0;
   endtask

   task automatic test_pause();
      do_load(8'd5);
      do_tick();
      do_tick();
      tests_run++; if (remaining !== 8'd3) begin tests_failed++; $display("FAIL pause_pre got=%0d exp=3", remaining); end
      pause = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         do_tick();
         tests_run++; if (remaining !== 8'd3) begin tests_failed++; $display("FAIL pause_hold k=%0d got=%0d exp=3", k, remaining); end
         tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL pause_busy k=%0d got=%b exp=1", k, busy); end
      end
      pause = 1'b0;
      step();
      tests_run++; if (remaining !== 8'd3) begin tests_failed++; $display("FAIL pause_resume got=%0d exp=3", remaining); end
      for (int k = 1; k <= 3; k++) begin
         do_tick();
         tests_run++; if (remaining !== 8'(3 - k)) begin tests_failed++; $display("FAIL pause_count k=%0d got=%0d exp=%0d", k, remaining, 3 - k); end
         tests_run++; if (expired !== (k == 3)) begin tests_failed++; $display("FAIL pause_exp k=%0d got=%b exp=%b", k, expired, k == 3); end
      end
   endtask

   task automatic test_abort_reload();
      do_load(8'd6);
      do_tick();
      do_tick();
      abort = 1'b1; step(); abort = 1'b0;
      tests_run++; if (remaining !== 8'd0) begin tests_failed++; $display("FAIL abort_rem got=%0d exp=0", remaining); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", busy); end
      tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL abort_exp got=%b exp=0", expired); end
      step();
      tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL abort_exp_late got=%b exp=0", expired); end
      // Mid-phase reload restarts the count from the new value.
      do_load(8'd6);
      do_tick();
      do_tick();
      do_load(8'd2);
      tests_run++; if (remaining !== 8'd2) begin tests_failed++; $display("FAIL reload_rem got=%0d exp=2", remaining); end
      do_tick();
      tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL reload_exp1 got=%b exp=0", expired); end
      do_tick();
      tests_run++; if (expired !== 1'b1) begin tests_failed++; $display("FAIL reload_exp2 got=%b exp=1", expired); end
      // Abort wins over a simultaneous load.
      do_load(8'd5);
      abort = 1'b1;
      do_load(8'd7);
      abort = 1'b0;
      tests_run++; if (remaining !== 8'd0) begin tests_failed++; $display("FAIL abort_load_rem got=%0d exp=0", remaining); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_load_busy got=%b exp=0", busy); end
      tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL abort_load_exp got=%b exp=0", expired); end
   endtask

   task automatic test_watchdog();
      do_load(8'd4);
      idle(7);
      tests_run++; if (tick_fault !== 1'b0) begin tests_failed++; $display("FAIL wd_gap7 got=%b exp=0", tick_fault); end
      step();
      tests_run++; if (tick_fault !== 1'b1) begin tests_failed++; $display("FAIL wd_gap8 got=%b exp=1", tick_fault); end
      idle(3);
      tests_run++; if (tick_fault !== 1'b1) begin tests_failed++; $display("FAIL wd_sticky got=%b exp=1", tick_fault); end
      tests_run++; if (busy !== 1'b1 || remaining !== 8'd4) begin tests_failed++; $display("FAIL wd_no_expiry busy=%b rem=%0d exp busy=1 rem=4", busy, remaining); end
      do_tick();
      do_tick();
      tests_run++; if (remaining !== 8'd2) begin tests_failed++; $display("FAIL wd_resume got=%0d exp=2", remaining); end
      tests_run++; if (tick_fault !== 1'b1) begin tests_failed++; $display("FAIL wd_sticky_tick got=%b exp=1", tick_fault); end
      do_load(8'd4);
      tests_run++; if (tick_fault !== 1'b0) begin tests_failed++; $display("FAIL wd_load_clear got=%b exp=0", tick_fault); end
      // Tick arrives at gap 7: the counter clears, no fault.
      idle(7);
      do_tick();
      tests_run++; if (tick_fault !== 1'b0) begin tests_failed++; $display("FAIL wd_tick_at7 got=%b exp=0", tick_fault); end
      tests_run++; if (remaining !== 8'd3) begin tests_failed++; $display("FAIL wd_tick_at7_rem got=%0d exp=3", remaining); end
      idle(1);
      tests_run++; if (tick_fault !== 1'b0) begin tests_failed++; $display("FAIL wd_after_clear got=%b exp=0", tick_fault); end
      abort = 1'b1; step(); abort = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_load(8'd5);
      do_tick();
      do_tick();
      idle(8);
      pause = 1'b1;
      step();
      tests_run++; if (remaining !== 8'd3 || tick_fault !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre rem=%0d fault=%b busy=%b exp rem=3 fault=1 busy=1", remaining, tick_fault, busy); end
      rst = 1'b1;
      step();
      rst   = 1'b0;
      pause = 1'b0;
      tests_run++; if (remaining !== 8'd0) begin tests_failed++; $display("FAIL rstmid_rem got=%0d exp=0", remaining); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL rstmid_exp got=%b exp=0", expired); end
      tests_run++; if (tick_fault !== 1'b0) begin tests_failed++; $display("FAIL rstmid_fault got=%b exp=0", tick_fault); end
      do_tick();
      do_tick();
      tests_run++; if (remaining !== 8'd0 || busy !== 1'b0 || expired !== 1'b0) begin tests_failed++; $display("FAIL idle_ticks rem=%0d busy=%b exp=%b want 0/0/0", remaining, busy, expired); end
      // Gap counter must also have been cleared by reset.
      do_load(8'd2);
      idle(7);
      tests_run++; if (tick_fault !== 1'b0) begin tests_failed++; $display("FAIL rstmid_gap_clear got=%b exp=0", tick_fault); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst      = 1'b1;
      tick     = 1'b0;
      load     = 1'b0;
      load_val = '0;
      pause    = 1'b0;
      abort    = 1'b0;
      step();
      test_reset();
      test_basic();
      test_zero_and_precedence();
      test_pause();
      test_abort_reload();
      test_watchdog();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
